// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// uart_pkg : shared constants, FSM encodings and width helper for the UART TX arbiter
// Revision : 1.0
// ============================================================================
package uart_pkg;

  localparam int DATA_W = 8;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_GRANT = 2'b01;
  localparam logic [1:0] ST_SEND  = 2'b10;
  localparam logic [1:0] ST_WAIT  = 2'b11;

  // Ceiling log2 with a floor of 1 so single-bit fields never collapse to zero width.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// rr_pick : combinational round-robin selector, first valid above rr_ptr (wrapping)
// Revision : 1.0
// ============================================================================
module rr_pick
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W-1:0] w_cand;

  // Scan from farthest to nearest so the nearest candidate (rr_ptr+1) wins.
  always_comb begin
    found  = 1'b0;
    idx    = '0;
    w_cand = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_cand = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (req_valid[w_cand]) begin
        found = 1'b1;
        idx   = w_cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// uart_tx_arbiter : packet-level round-robin arbiter sharing one UART serializer
// Revision : 1.0
// ============================================================================
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_W       = uart_pkg::DATA_W,
  parameter int HOLD_TIMEOUT = 1024
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_REQ-1:0]                    req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]             req_data,
  input  logic [NUM_REQ-1:0]                    req_last,
  output logic [NUM_REQ-1:0]                    req_ready,
  output logic [DATA_W-1:0]                     tx_data,
  output logic                                  tx_start,
  input  logic                                  tx_ready,
  output logic [uart_pkg::clog2(NUM_REQ)-1:0]   grant_id,
  output logic                                  busy,
  output logic                                  err_timeout,
  output logic [1:0]                            present_state
);
  import uart_pkg::*;

  localparam int GW = clog2(NUM_REQ);
  localparam int CW = clog2(HOLD_TIMEOUT + 1);
  localparam logic [CW-1:0] c_hold_max = CW'(HOLD_TIMEOUT - 1);

  logic [1:0]         r_state;
  logic [GW-1:0]      r_rr_ptr;
  logic               r_last;
  logic [CW-1:0]      r_hold_cnt;

  logic               w_found;
  logic [GW-1:0]      w_pick;
  logic               w_sel_valid;
  logic               w_sel_last;
  logic [DATA_W-1:0]  w_sel_data;
  logic [NUM_REQ-1:0] w_grant_onehot;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (GW)
  ) u_rr_pick (
    .req_valid (req_valid),
    .rr_ptr    (r_rr_ptr),
    .found     (w_found),
    .idx       (w_pick)
  );

  // Route the granted requester's handshake signals onto a single lane.
  always_comb begin
    w_sel_valid    = 1'b0;
    w_sel_last     = 1'b0;
    w_sel_data     = '0;
    w_grant_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (GW'(i) == grant_id) begin
        w_sel_valid       = req_valid[i];
        w_sel_last        = req_last[i];
        w_sel_data        = req_data[i*DATA_W +: DATA_W];
        w_grant_onehot[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= GW'(NUM_REQ - 1);
      r_last      <= 1'b0;
      r_hold_cnt  <= '0;
      req_ready   <= '0;
      tx_data     <= '0;
      tx_start    <= 1'b0;
      grant_id    <= '0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      req_ready   <= '0;
      tx_start    <= 1'b0;
      err_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            grant_id   <= w_pick;
            busy       <= 1'b1;
            r_hold_cnt <= '0;
            r_state    <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (w_sel_valid && tx_ready) begin
            tx_data    <= w_sel_data;
            r_last     <= w_sel_last;
            tx_start   <= 1'b1;
            req_ready  <= w_grant_onehot;
            r_hold_cnt <= '0;
            r_state    <= ST_SEND;
          end else if (!w_sel_valid) begin
            if (r_hold_cnt == c_hold_max) begin
              err_timeout <= 1'b1;
              r_rr_ptr    <= grant_id;
              busy        <= 1'b0;
              r_hold_cnt  <= '0;
              r_state     <= ST_IDLE;
            end else begin
              r_hold_cnt <= r_hold_cnt + CW'(1);
            end
          end else begin
            // Serializer back-pressure is not the requester's fault.
            r_hold_cnt <= '0;
          end
        end
        ST_SEND: begin
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (tx_ready) begin
            r_hold_cnt <= '0;
            if (r_last) begin
              r_rr_ptr <= grant_id;
              busy     <= 1'b0;
              r_state  <= ST_IDLE;
            end else begin
              r_state <= ST_GRANT;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign present_state = r_state;

endmodule
`default_nettype wire
